// File: rtl/parity_check_rx_if.sv
// Output-side valid/ready port of the parity-checking frame receiver.
interface parity_check_rx_if #(
  parameter int DATA_W = 3
) ();
  logic [DATA_W-1:0] data;
  logic              parity_err;
  logic              out_valid;
  logic              out_ready;

  modport master (output data, output parity_err, output out_valid, input out_ready);
  modport slave  (input data, input parity_err, input out_valid, output out_ready);
endinterface

// File: rtl/parity_check_rx.sv
// Serial frame receiver: DATA_W data bits LSB first plus a parity bit, checked and
// presented through a single-entry valid/ready buffer with sticky overrun.
module parity_check_rx #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  input  logic                      frame_start,
  parity_check_rx_if.master         out_if,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                err_q, err_n;
  logic                valid_q, valid_n;
  logic                ovr_q, ovr_n;
  logic                rx_err;
  logic                buf_free;

  assign rx_err   = (^shift_q) ^ bit_in ^ ODD;
  assign buf_free = !valid_q || out_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      err_q   <= err_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shift_n = shift_q;
    data_n  = data_q;
    err_n   = err_q;
    valid_n = valid_q;
    ovr_n   = ovr_q;

    if (valid_q && out_if.out_ready) valid_n = 1'b0;
    // Clear first so a same-cycle overrun set below takes priority.
    if (overrun_clr) ovr_n = 1'b0;

    if (bit_valid) begin
      if (frame_start) begin
        shift_n    = '0;
        shift_n[0] = bit_in;
        cnt_n      = CNT_W'(1);
        state_n    = RECV;
      end else if (state_q == RECV) begin
        if (cnt_q < CNT_W'(DATA_W)) begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_n[i] = bit_in;
          end
          cnt_n = cnt_q + CNT_W'(1);
        end else begin
          if (buf_free) begin
            data_n  = shift_q;
            err_n   = rx_err;
            valid_n = 1'b1;
          end else begin
            ovr_n = 1'b1;
          end
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
    end
  end

  assign out_if.data       = data_q;
  assign out_if.parity_err = err_q;
  assign out_if.out_valid  = valid_q;
  assign overrun           = ovr_q;
  assign busy              = (state_q == RECV);
endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Receive-side partner of the team's even-parity generator.
- Deserialises a bit stream of frames: DATA_W data bits sent LSB first, then one parity bit.
- Checks the parity bit, then presents the data word and an error flag on a valid/ready output port.
- A single-entry output buffer decouples the serial side from the downstream consumer. Lost frames are flagged as overrun.

Parameters:
- DATA_W, 3, data bits per frame (legal range >= 1).
- ODD, 0, parity sense. 0 = even parity: the expected parity bit is the XOR of the data bits. 1 = odd parity: the expected parity bit is the inverted XOR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial data/parity bit.
- bit_valid  input  1  bit_in is sampled on cycles where this is high.
- frame_start  input  1  qualifies bit_valid. Marks bit_in as data bit 0 of a new frame. Ignored when bit_valid is low.
- data  output  DATA_W  received data word.
- parity_err  output  1  high when the received parity bit mismatches the computed parity for the word on data.
- out_valid  output  1  data and parity_err hold a frame.
- out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
- overrun  output  1  sticky: a completed frame was dropped because the buffer was full.
- overrun_clr  input  1  synchronous clear of overrun.
- busy  output  1  high while a frame is partially received (state RECV).

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. Under reset: state=IDLE, bit counter=0, shift register=0, data=0, parity_err=0, out_valid=0, overrun=0, busy=0.
- State IDLE:
  - bit_valid && !frame_start: bit ignored.
  - bit_valid && frame_start: bit_in -> shift[0], cnt=1, go to RECV.
- State RECV, on each bit_valid cycle:
  - frame_start=1: abort the partial frame. bit_in -> shift[0], cnt=1, stay in RECV. Nothing is emitted.
  - frame_start=0 and cnt<DATA_W: bit_in -> shift[cnt], cnt++.
  - frame_start=0 and cnt==DATA_W: bit_in is the parity bit. Compute err = XOR(shift) ^ bit_in ^ ODD. Attempt to load the buffer (rules below), then go to IDLE with cnt=0.
- Gaps: cycles with bit_valid low do not advance the state or the counter. Gaps of any length are legal.
- DATA_W=1: the bit after the frame_start bit is the parity bit.
- Buffer load:
  - Condition: buffer free, i.e. !out_valid, or out_valid && out_ready in the same cycle.
  - On load: data<=shift, parity_err<=err, out_valid<=1 on the next clock edge. Latency is 1 cycle from the clock sampling the parity bit.
  - If the buffer is full and not draining: the new frame is discarded, overrun<=1, and the held data/parity_err are unchanged.
- Handshake:
  - While out_valid && !out_ready, data and parity_err stay stable.
  - On out_valid && out_ready with no simultaneous load, out_valid<=0. data and parity_err keep their last values.
  - Simultaneous drain and load: out_valid stays 1 and the new frame replaces the old one.
- overrun: cleared by overrun_clr. If a set and overrun_clr occur in the same cycle, the set wins.
- busy: equals (state==RECV).
- Reset mid-frame: the partial frame is lost. No output is produced after reset until a new frame_start.

Test Plan:
1. Clean frame, DATA_W=3, ODD=0. Sequence: fs+bit 1, bit 0, bit 1, parity 0, back-to-back. -> One cycle after the parity sample: out_valid=1, data=3'b101, parity_err=0. out_ready=1 -> out_valid=0 the next cycle.
2. Parity error with gaps. Data bits 1,1,0 (word 3'b011), then parity 1, with 2 idle cycles between bits. -> data=3'b011, parity_err=1. busy is high from the first bit until the parity bit, and counts did not advance during the gaps.
3. Backpressure and overrun. out_ready=0 while frame 3'b101/p0 loads, then frame 3'b011/p0 completes. -> data stays 3'b101, overrun=1. overrun_clr pulse -> overrun=0. Then frame 3'b111 with parity 0 and out_ready=1 in the parity-completion cycle -> data=3'b111, parity_err=1, out_valid stays 1 (simultaneous drain and load).
4. Abort and resync. Send fs+1, 0, then fs+0, 1, 1, parity 0. -> Exactly one frame: data=3'b110, parity_err=0. The aborted frame is never emitted.
5. Reset mid-frame. Send fs+1, 1, then assert rst_n=0 asynchronously between clock edges. -> All outputs go to 0 immediately. After release, non-fs bits are ignored until a frame_start arrives.
6. ODD=1, DATA_W=1. Send fs+1, parity 0. -> data=1, parity_err=0. Send fs+1, parity 1 -> data=1, parity_err=1.
